// File: rtl/sparse_coo_mm_scheduler.sv
// Loads one job of COO entries for A and B, then walks every (A, B) pair and
// issues the index-matching ones (A.col == B.row) to the MAC, one per cycle.
module sparse_coo_mm_scheduler #(
  parameter int NNZ_MAX = 8,
  parameter int IDX_W   = 3,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = $clog2(NNZ_MAX + 1),
  parameter int PCNT_W  = $clog2(NNZ_MAX * NNZ_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  a_cnt,
  input  logic [CNT_W-1:0]  b_cnt,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [IDX_W-1:0]  ld_row,
  input  logic [IDX_W-1:0]  ld_col,
  input  logic [DATA_W-1:0] ld_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [IDX_W-1:0]  iss_row,
  output logic [IDX_W-1:0]  iss_col,
  output logic              clear_acc,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] pair_cnt
);

  localparam int PTR_W = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, SCAN, DONE} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  a_row [NNZ_MAX];
  logic [IDX_W-1:0]  a_col [NNZ_MAX];
  logic [DATA_W-1:0] a_dat [NNZ_MAX];
  logic [IDX_W-1:0]  b_row [NNZ_MAX];
  logic [IDX_W-1:0]  b_col [NNZ_MAX];
  logic [DATA_W-1:0] b_dat [NNZ_MAX];

  logic [CNT_W-1:0] a_n, b_n;
  logic [PTR_W-1:0] ptr, i, j;

  logic [CNT_W-1:0] a_cnt_c, b_cnt_c;
  logic             ptr_last_a, ptr_last_b, i_last, j_last;
  logic             empty, match, advance, iss_fire;

  // Oversized requests are clamped to the storage depth.
  assign a_cnt_c = (a_cnt > CNT_W'(NNZ_MAX)) ? CNT_W'(NNZ_MAX) : a_cnt;
  assign b_cnt_c = (b_cnt > CNT_W'(NNZ_MAX)) ? CNT_W'(NNZ_MAX) : b_cnt;

  assign ptr_last_a = (CNT_W'(ptr) == a_n - CNT_W'(1));
  assign ptr_last_b = (CNT_W'(ptr) == b_n - CNT_W'(1));
  assign i_last     = (CNT_W'(i) == a_n - CNT_W'(1));
  assign j_last     = (CNT_W'(j) == b_n - CNT_W'(1));
  assign empty      = (a_n == '0) || (b_n == '0);
  assign match      = (a_col[i] == b_row[j]);
  assign advance    = !iss_valid || iss_ready;
  assign iss_fire   = iss_valid && iss_ready;

  // Payload is forced to zero when nothing is presented so reset shows all-zero outputs.
  assign iss_row = iss_valid ? a_row[i] : '0;
  assign iss_col = iss_valid ? b_col[j] : '0;
  assign iss_a   = iss_valid ? a_dat[i] : '0;
  assign iss_b   = iss_valid ? b_dat[j] : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    state_nxt = state;
    ld_ready  = 1'b0;
    iss_valid = 1'b0;
    clear_acc = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && !rst) begin
          clear_acc = 1'b1;
          if (a_cnt_c != '0)      state_nxt = LOAD_A;
          else if (b_cnt_c != '0) state_nxt = LOAD_B;
          else                    state_nxt = SCAN;
        end
      end
      LOAD_A: begin
        ld_ready = 1'b1;
        if (ld_valid && ptr_last_a) state_nxt = (b_n != '0) ? LOAD_B : SCAN;
      end
      LOAD_B: begin
        ld_ready = 1'b1;
        if (ld_valid && ptr_last_b) state_nxt = SCAN;
      end
      SCAN: begin
        iss_valid = !empty && match;
        if (empty || ((!iss_valid || iss_ready) && i_last && j_last)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_n      <= '0;
      b_n      <= '0;
      ptr      <= '0;
      i        <= '0;
      j        <= '0;
      pair_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_n      <= a_cnt_c;
            b_n      <= b_cnt_c;
            ptr      <= '0;
            i        <= '0;
            j        <= '0;
            pair_cnt <= '0;
          end
        end
        LOAD_A: if (ld_valid) ptr <= ptr_last_a ? '0 : ptr + PTR_W'(1);
        LOAD_B: if (ld_valid) ptr <= ptr_last_b ? '0 : ptr + PTR_W'(1);
        SCAN: begin
          if (iss_fire) pair_cnt <= pair_cnt + PCNT_W'(1);
          // j is the inner index; indices hold under backpressure so the payload stays stable.
          if (!empty && advance) begin
            if (j_last) begin
              j <= '0;
              if (!i_last) i <= i + PTR_W'(1);
            end else begin
              j <= j + PTR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: entry storage has no reset; every slot read in SCAN was written during the load phase.
  always_ff @(posedge clk) begin
    if (state == LOAD_A && ld_valid) begin
      a_row[ptr] <= ld_row;
      a_col[ptr] <= ld_col;
      a_dat[ptr] <= ld_data;
    end
    if (state == LOAD_B && ld_valid) begin
      b_row[ptr] <= ld_row;
      b_col[ptr] <= ld_col;
      b_dat[ptr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_sparse_coo_mm_scheduler.sv
// Directed bench for sparse_coo_mm_scheduler: a job table run in a loop plus
// hand-written reset, backpressure and mid-scan reset sequences.
module tb_sparse_coo_mm_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_cnt, b_cnt;
  logic       ld_valid, ld_ready;
  logic [2:0] ld_row, ld_col;
  logic [7:0] ld_data;
  logic       iss_valid, iss_ready;
  logic [7:0] iss_a, iss_b;
  logic [2:0] iss_row, iss_col;
  logic       clear_acc, busy, done;
  logic [6:0] pair_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  sparse_coo_mm_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .a_cnt(a_cnt), .b_cnt(b_cnt),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_row(ld_row), .ld_col(ld_col),
    .ld_data(ld_data), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_a(iss_a), .iss_b(iss_b), .iss_row(iss_row), .iss_col(iss_col),
    .clear_acc(clear_acc), .busy(busy), .done(done), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] data;
  } ent_t;

  typedef struct packed {
    logic [7:0] cyc;
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] a;
    logic [7:0] b;
  } iss_t;

  typedef struct {
    int   a_cnt;
    int   b_cnt;
    int   a_n;
    int   b_n;
    bit   gaps;
    ent_t a [8];
    ent_t b [8];
    int   pairs;
    int   scan;
    int   n_iss;
    iss_t iss [8];
  } job_t;

  job_t jobs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic hdr(input int x, input int ac, input int bc, input int an, input int bn,
                     input bit g, input int p, input int s, input int ni);
    jobs[x].a_cnt = ac; jobs[x].b_cnt = bc; jobs[x].a_n = an; jobs[x].b_n = bn;
    jobs[x].gaps = g; jobs[x].pairs = p; jobs[x].scan = s; jobs[x].n_iss = ni;
  endtask

  task automatic fill_jobs();
    // 0: empty job
    hdr(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // 1: single match -> (row2,col5,a=38,b=40)
    hdr(1, 1, 1, 1, 1, 0, 1, 1, 1);
    jobs[1].a[0] = '{3'd2, 3'd3, 8'h38};
    jobs[1].b[0] = '{3'd3, 3'd5, 8'h40};
    jobs[1].iss[0] = '{8'd0, 3'd2, 3'd5, 8'h38, 8'h40};
    // 2: no match
    hdr(2, 1, 1, 1, 1, 0, 0, 1, 0);
    jobs[2].a[0] = '{3'd1, 3'd1, 8'h38};
    jobs[2].b[0] = '{3'd2, 3'd4, 8'h40};
    // 3: diagonal full load, pair (k,k) appears at scan cycle 9k
    hdr(3, 8, 8, 8, 8, 0, 8, 64, 8);
    for (int k = 0; k < 8; k++) begin
      jobs[3].a[k]   = '{3'(k), 3'(k), 8'(8'h38 + k)};
      jobs[3].b[k]   = '{3'(k), 3'(k), 8'(8'h38 + k)};
      jobs[3].iss[k] = '{8'(9 * k), 3'(k), 3'(k), 8'(8'h38 + k), 8'(8'h38 + k)};
    end
    // 4: a_cnt=9 clamped to 8, load gaps; only A[5].col==B[0].row
    hdr(4, 9, 1, 8, 1, 1, 1, 8, 1);
    for (int k = 0; k < 8; k++) jobs[4].a[k] = '{3'(k), 3'(k), 8'(8'h10 + k)};
    jobs[4].b[0] = '{3'd5, 3'd2, 8'h77};
    jobs[4].iss[0] = '{8'd5, 3'd5, 3'd2, 8'h15, 8'h77};
    // 5: two pairs hitting the same (1,4) target on separate cycles
    hdr(5, 2, 2, 2, 2, 0, 2, 4, 2);
    jobs[5].a[0] = '{3'd1, 3'd2, 8'h11};
    jobs[5].a[1] = '{3'd1, 3'd3, 8'h12};
    jobs[5].b[0] = '{3'd2, 3'd4, 8'h21};
    jobs[5].b[1] = '{3'd3, 3'd4, 8'h22};
    jobs[5].iss[0] = '{8'd0, 3'd1, 3'd4, 8'h11, 8'h21};
    jobs[5].iss[1] = '{8'd3, 3'd1, 3'd4, 8'h12, 8'h22};
  endtask

  task automatic send_entry(input ent_t e, input bit gap);
    @(negedge clk);
    if (gap) begin
      ld_valid = 1'b0;
      @(negedge clk);
    end
    for (int w = 0; w < 20 && !ld_ready; w++) @(negedge clk);
    check("ld_ready", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1;
    {ld_row, ld_col, ld_data} = e;
    @(posedge clk);
  endtask

  // Accepts start, then streams all A and B entries; returns just after the last accepting edge.
  task automatic load_job(input int x);
    @(negedge clk);
    start = 1'b1;
    a_cnt = 4'(jobs[x].a_cnt);
    b_cnt = 4'(jobs[x].b_cnt);
    #1;
    check("clear_acc_at_start", 32'(clear_acc), 32'd1);
    check("idle_before_start", 32'(busy), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < jobs[x].a_n; k++) send_entry(jobs[x].a[k], jobs[x].gaps);
    for (int k = 0; k < jobs[x].b_n; k++) send_entry(jobs[x].b[k], jobs[x].gaps);
    #1 ld_valid = 1'b0;
  endtask

  // Observes SCAN with iss_ready=1; with noise set, start is held high to prove it is ignored.
  task automatic scan_job(input int x, input bit noise);
    int  sc   = 0;
    int  ni   = 0;
    bit  seen = 0;
    iss_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        check("done_iss_valid", 32'(iss_valid), 32'd0);
        check("pair_cnt", 32'(pair_cnt), 32'(jobs[x].pairs));
        check("scan_cycles", 32'(sc), 32'(jobs[x].scan));
        check("issue_count", 32'(ni), 32'(jobs[x].n_iss));
        check("no_ld_ready_in_done", 32'(ld_ready), 32'd0);
        start = 1'b0;
      end else begin
        check("no_ld_ready_in_scan", 32'(ld_ready), 32'd0);
        if (iss_valid) begin
          if (ni < jobs[x].n_iss) begin
            check("iss_cycle", 32'(sc), 32'(jobs[x].iss[ni].cyc));
            check("iss_row", 32'(iss_row), 32'(jobs[x].iss[ni].row));
            check("iss_col", 32'(iss_col), 32'(jobs[x].iss[ni].col));
            check("iss_a", 32'(iss_a), 32'(jobs[x].iss[ni].a));
            check("iss_b", 32'(iss_b), 32'(jobs[x].iss[ni].b));
          end else begin
            check("extra_issue", 32'(ni + 1), 32'(jobs[x].n_iss));
          end
          ni++;
        end
        if (noise) begin
          check("clear_acc_while_busy", 32'(clear_acc), 32'd0);
          start = 1'b1;
          a_cnt = 4'd1;
          b_cnt = 4'd1;
        end
        sc++;
      end
    end
    if (!seen) check("done_timeout", 32'(seen), 32'd1);
    @(negedge clk);
    check("idle_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a_cnt = '0; b_cnt = '0; ld_valid = 1'b0;
    ld_row = '0; ld_col = '0; ld_data = '0; iss_ready = 1'b0;
    fill_jobs();

    // Reset held three cycles with random inputs: every output stays zero.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      {start, a_cnt, b_cnt, ld_valid, ld_row, ld_col, ld_data, iss_ready} = 25'($urandom);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_iss_valid", 32'(iss_valid), 32'd0);
      check("rst_clear_acc", 32'(clear_acc), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pair_cnt", 32'(pair_cnt), 32'd0);
      check("rst_payload", 32'({iss_row, iss_col, iss_a, iss_b}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; a_cnt = '0; b_cnt = '0; ld_valid = 1'b0; iss_ready = 1'b0;

    // Table-driven jobs: empty, single match, no match, diagonal, clamped with gaps.
    for (int x = 0; x < 5; x++) begin
      load_job(x);
      scan_job(x, 1'b0);
    end

    // Backpressure: the single-match pair waits three cycles with a stable payload.
    load_job(1);
    iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(iss_valid), 32'd1);
      check("bp_payload", 32'({iss_row, iss_col, iss_a, iss_b}), {8'd0, 3'd2, 3'd5, 8'h38, 8'h40});
      check("bp_pair_cnt", 32'(pair_cnt), 32'd0);
      if (k == 3) iss_ready = 1'b1;
    end
    @(negedge clk);
    check("bp_done", 32'(done), 32'd1);
    check("bp_pair_cnt_final", 32'(pair_cnt), 32'd1);
    check("bp_valid_after", 32'(iss_valid), 32'd0);
    @(negedge clk);
    check("bp_idle", 32'(busy), 32'd0);

    // Reset during the diagonal scan after three handshakes aborts the job.
    load_job(3);
    iss_ready = 1'b1;
    begin
      int hs = 0;
      for (int cyc = 0; cyc < 100 && hs < 3; cyc++) begin
        @(negedge clk);
        if (iss_valid) hs++;
      end
      check("pre_abort_issues", 32'(hs), 32'd3);
    end
    @(negedge clk);
    check("pre_abort_pair_cnt", 32'(pair_cnt), 32'd3);
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_iss_valid", 32'(iss_valid), 32'd0);
    check("abort_pair_cnt", 32'(pair_cnt), 32'd0);

    // Fresh job after the abort, with start held high while busy.
    load_job(5);
    scan_job(5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sparse_coo_mm_scheduler.md
Name: sparse_coo_mm_scheduler

Overview:
Sequencer for the sparse COO FP8 matrix-multiply datapath. It loads one job of COO entries for A and B over a valid/ready load port into local storage. It then scans every (A entry, B entry) pair and issues each index-matching pair (A.col == B.row) to the downstream multiply-accumulate unit over a valid/ready issue port. It pulses clear_acc at job start and done at job end, replacing the unsequenced all-pairs-per-cycle loop with one product per cycle.

Parameters:
NNZ_MAX, 8, max stored entries per matrix (A and B each)
IDX_W, 3, row/column index width (matrix dimension 2**IDX_W)
DATA_W, 8, element width (FP8 E4M3 bit pattern, passed through untouched)
CNT_W, $clog2(NNZ_MAX+1), width of entry counts
PCNT_W, $clog2(NNZ_MAX*NNZ_MAX+1), width of pair counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  job request, sampled only in IDLE
a_cnt  in  CNT_W  number of A entries, latched when start accepted
b_cnt  in  CNT_W  number of B entries, latched when start accepted
ld_valid  in  1  load entry valid
ld_ready  out  1  high in LOAD_A/LOAD_B only
ld_row  in  IDX_W  entry row index
ld_col  in  IDX_W  entry column index
ld_data  in  DATA_W  entry value
iss_valid  out  1  matching pair presented
iss_ready  in  1  MAC accepts pair
iss_a  out  DATA_W  A value of current pair
iss_b  out  DATA_W  B value of current pair
iss_row  out  IDX_W  destination row (A.row)
iss_col  out  IDX_W  destination column (B.col)
clear_acc  out  1  one-cycle pulse: clear MAC accumulator
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse in DONE state
pair_cnt  out  PCNT_W  matching pairs issued in current/last job

Behaviour:
- Reset: state IDLE, i=j=0, load pointer 0, pair_cnt=0; all outputs 0. Entry storage not cleared (contents don't-care). Reset mid-job aborts immediately; iss_valid is 0 the following cycle.
- States: IDLE, LOAD_A, LOAD_B, SCAN, DONE.
- IDLE: start=1 latches counts, clamping any count > NNZ_MAX to NNZ_MAX. Same cycle: clear_acc=1, pair_cnt<=0. Next state is LOAD_A if a_cnt>0, else LOAD_B if b_cnt>0, else SCAN.
- LOAD_A/LOAD_B: ld_ready=1. Each ld_valid&ld_ready writes {row,col,data} at the pointer and increments it. After the a_cnt-th A entry, go to LOAD_B (or SCAN if b_cnt=0), pointer resets to 0. After the b_cnt-th B entry, go to SCAN. Loads are in order: all A, then all B.
- start is ignored outside IDLE.
- SCAN: current pair is (A[i], B[j]), j inner and i outer, both from 0.
  - iss_valid = (A[i].col == B[j].row), combinational from stored registers.
  - Payload: iss_row=A[i].row, iss_col=B[j].col, iss_a=A[i].data, iss_b=B[j].data.
  - Advance when !iss_valid or iss_ready. Indices hold otherwise, so the payload stays stable under backpressure.
  - On handshake, pair_cnt++.
  - Advancing from the last pair (i=a_cnt-1, j=b_cnt-1) goes to DONE.
  - If a_cnt=0 or b_cnt=0: SCAN lasts exactly 1 cycle with iss_valid=0, then DONE.
- DONE: done=1 for one cycle, iss_valid=0, then IDLE. pair_cnt holds until next start.
- Throughput: with iss_ready=1, SCAN takes max(1, a_cnt*b_cnt) cycles regardless of matches.
- Multiple pairs targeting the same (row,col) are issued on separate cycles; accumulation is the MAC's job.
- Outputs during IDLE/LOAD: iss_valid=0. Payload is don't-care when iss_valid=0.

Test Plan:
1. Reset asserted 3 cycles with random inputs -> all outputs 0, busy=0, ld_ready=0. Then start with a_cnt=b_cnt=0 at cycle T -> clear_acc=1 at T, done=1 at T+2, busy=0 at T+3, no ld_ready, pair_cnt=0.
2. Single match: A={row2,col3,0x38}, B={row3,col5,0x40} -> exactly one issue (row2,col5,a=0x38,b=0x40), pair_cnt=1, done next cycle after issue.
3. No match: A={row1,col1,0x38}, B={row2,col4,0x40} -> SCAN 1 cycle with iss_valid=0, done, pair_cnt=0.
4. Diagonal full load: A[k]=B[k]={row k,col k,0x38+k}, k=0..7, iss_ready=1 -> SCAN 64 cycles. 8 issues in order k=0..7 at scan cycles 9k, each (k,k). pair_cnt=8.
5. Backpressure: test 2 with iss_ready low 3 cycles then high -> iss_valid held 4 cycles with stable payload, single handshake. Load with ld_valid gaps and a_cnt=9 -> clamped to 8 entries.
6. rst pulsed during SCAN of test 4 after 3 issues -> IDLE next cycle, iss_valid=0, pair_cnt=0. A fresh job then runs correctly, and start asserted while busy is ignored.
